tmds_diff_obuf: RTL and testbench



---
 rtl/tmds_pkg.sv | 16 +
 rtl/diff_obuf_lane.sv | 49 ++++
 rtl/tmds_diff_obuf.sv | 34 +++
 tb/tb_tmds_diff_obuf.sv | 110 +++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS transmit constants: lane count, lane indices and default
// retime/polarity masks for the differential output bank.
package tmds_pkg;

  localparam int TMDS_LANES = 4;

  localparam int LANE_RED   = 0;
  localparam int LANE_GREEN = 1;
  localparam int LANE_BLUE  = 2;
  localparam int LANE_CLK   = 3;

  // The clock lane stays combinational so the pixel clock never crosses a flop.
  localparam logic [TMDS_LANES-1:0] TMDS_REG_MASK = 4'b0111;
  localparam logic [TMDS_LANES-1:0] TMDS_INV_MASK = 4'b0000;

endpackage

// File: rtl/diff_obuf_lane.sv
// One differential output lane: optional retiming flop, static plus
// run-time polarity swap, and tristate P/N drive.
module diff_obuf_lane #(
  parameter bit REGISTERED = 1'b1,
  parameter bit INVERT     = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  input  logic inv,
  input  logic oe,
  output logic p,
  output logic n
);

  logic d_sel;
  logic s;

  if (REGISTERED) begin : g_reg
    logic r_q, r_d;
    assign r_d = d;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_q <= 1'b0;
      else         r_q <= r_d;
    end
    assign d_sel = r_q;
  end else begin : g_comb
    // Unused in this lane; kept so both branches share one port list.
    logic unused_clk;
    assign unused_clk = clk ^ resetn;
    assign d_sel = d;
  end

  // XOR keeps X on the input visible on both pins instead of a stale level.
  assign s = d_sel ^ INVERT ^ inv;

`ifdef TMDS_USE_OBUFDS
  OBUFTDS u_obuf (
    .I  (s),
    .T  (~oe),
    .O  (p),
    .OB (n)
  );
`else
  assign p = oe ? s  : 1'bz;
  assign n = oe ? ~s : 1'bz;
`endif

endmodule

// File: rtl/tmds_diff_obuf.sv
// TMDS differential output buffer bank: one diff_obuf_lane per lane,
// sitting between the serializer shift registers and the pins.
module tmds_diff_obuf
  import tmds_pkg::*;
#(
  parameter int               LANES    = TMDS_LANES,
  parameter logic [LANES-1:0] REG_MASK = LANES'(TMDS_REG_MASK),
  parameter logic [LANES-1:0] INV_MASK = LANES'(TMDS_INV_MASK)
) (
  input  logic             i_tmds_clk,
  input  logic             i_resetn,
  input  logic [LANES-1:0] i_data,
  input  logic [LANES-1:0] i_invert,
  input  logic             i_oe,
  output logic [LANES-1:0] o_p,
  output logic [LANES-1:0] o_n
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    diff_obuf_lane #(
      .REGISTERED (REG_MASK[k]),
      .INVERT     (INV_MASK[k])
    ) u_lane (
      .clk    (i_tmds_clk),
      .resetn (i_resetn),
      .d      (i_data[k]),
      .inv    (i_invert[k]),
      .oe     (i_oe),
      .p      (o_p[k]),
      .n      (o_n[k])
    );
  end

endmodule

// File: tb/tb_tmds_diff_obuf.sv
// Directed bench for tmds_diff_obuf with default masks (lanes 0-2 retimed,
// lane 3 combinational). Inputs change on the falling edge.
module tb_tmds_diff_obuf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data, inv;
  logic       oe;
  logic [3:0] o_p, o_n;

  int n_cmp = 0;
  int n_bad = 0;

  tmds_diff_obuf dut (
    .i_tmds_clk (clk),
    .i_resetn   (rst_n),
    .i_data     (data),
    .i_invert   (inv),
    .i_oe       (oe),
    .o_p        (o_p),
    .o_n        (o_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_pn(input string tag, input logic [3:0] exp_p);
    chk({tag, "_p"}, o_p, exp_p);
    chk({tag, "_n"}, o_n, ~exp_p);
  endtask

  logic [4:0] pat;
  logic       prev;

  initial begin
    rst_n = 1'b0; oe = 1'b1; inv = 4'b0000; data = 4'b1111;
    #2;
    chk_pn("reset_all_ones", 4'b1000);
    data = 4'b0000; #1;
    chk_pn("reset_comb_lane", 4'b0000);

    // Release reset, then shift 1,0,1,1,0 through lane 0.
    @(negedge clk); rst_n = 1'b1;
    pat  = 5'b01101;   // pat[i] is the i-th serial bit
    prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data[0] = pat[i]; #1;
      chk("lat_hold_p0", {3'b0, o_p[0]}, {3'b0, prev});
      @(negedge clk);
      chk("lat_p0", {3'b0, o_p[0]}, {3'b0, pat[i]});
      chk("lat_n0", {3'b0, o_n[0]}, {3'b0, ~pat[i]});
      prev = pat[i];
    end

    // Clock lane follows its input between edges.
    #1 data[3] = 1'b1; #1;
    chk("clk_lane_hi_p", {3'b0, o_p[3]}, 4'b0001);
    chk("clk_lane_hi_n", {3'b0, o_n[3]}, 4'b0000);
    data[3] = 1'b0; #1;
    chk("clk_lane_lo_p", {3'b0, o_p[3]}, 4'b0000);
    chk("clk_lane_lo_n", {3'b0, o_n[3]}, 4'b0001);

    // Polarity swap on lane 1.
    @(negedge clk); data = 4'b0010; inv = 4'b0010;
    @(negedge clk);
    chk_pn("invert_on", 4'b0000);
    inv = 4'b0000; #1;
    chk_pn("invert_off", 4'b0010);

    // Tristate; registers keep loading while disabled.
    @(negedge clk); data = 4'b0111;
    @(negedge clk); oe = 1'b0; #1;
    n_cmp++;
    assert (o_p === 4'bzzzz) else begin
      n_bad++; $error("FAIL oe_off_p: got %b expected zzzz", o_p);
    end
    n_cmp++;
    assert (o_n === 4'bzzzz) else begin
      n_bad++; $error("FAIL oe_off_n: got %b expected zzzz", o_n);
    end
    data = 4'b0101;
    @(negedge clk); oe = 1'b1; #1;
    chk_pn("oe_back_on", 4'b0101);

    // Reset mid-stream between edges.
    data = 4'b0111;
    @(negedge clk);
    chk_pn("pre_mid_reset", 4'b0111);
    #2 rst_n = 1'b0; #1;
    chk_pn("mid_reset_now", 4'b0000);
    @(negedge clk);
    chk_pn("mid_reset_hold", 4'b0000);
    rst_n = 1'b1; data = 4'b0101; #1;
    chk_pn("release_no_edge", 4'b0000);
    @(negedge clk);
    chk_pn("release_first_load", 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
